lbp_engine: RTL and testbench

Local Binary Pattern engine for 8-bit grayscale frames, acting as the initiator on the gray-memory read interface and the writer on the LBP-memory write interface. It fetches pixels on request, computes the 8-bit LBP code for every interior pixel using a sliding 3x3 window, and writes each code to the result memory. It asserts `finish` when the frame is complete. It is the compute core that the host-side gray memory and the LBP result memory attach to.

---
 rtl/lbp_engine.sv | 147 ++++++++++++++
 tb/tb_lbp_engine.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lbp_engine.sv
// lbp_engine: sliding 3x3 Local Binary Pattern engine over a gray frame; define LBP_BORDER_WRITE_EN to zero-fill border codes
module lbp_engine #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, BORDER, DONE} state_t;
  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    r_q, r_d;
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic          gray_req_q, gray_req_d;
  logic [AW-1:0] gray_addr_q, gray_addr_d;
  logic          lbp_valid_q, lbp_valid_d;
  logic [AW-1:0] lbp_addr_q, lbp_addr_d;
  logic [7:0]    lbp_data_q, lbp_data_d;
  logic          finish_q, finish_d;
  logic [63:0]   nbr;
  logic [7:0]    code;
  function automatic logic [AW-1:0] addr_of(input logic [YW-1:0] row, input logic [XW-1:0] col);
    return AW'(row) * AW'(IMG_W) + AW'(col);
  endfunction
  // LBP code of the current window, with the bottom-right pixel taken straight off the read bus
  always_comb begin
    code = '0;
    nbr = {gray_data, win_q[2][1], win_q[2][0], win_q[1][2], win_q[1][0], win_q[0][2], win_q[0][1], win_q[0][0]};
    for (int i = 0; i < 8; i++) code[i] = nbr[8*i +: 8] >= win_q[1][1];
  end
  // next state: counters track the read being issued; requests are registered one cycle ahead
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    r_d         = r_q;
    win_d       = win_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q;
    case (state_q)
      IDLE: state_d = gray_ready ? FETCH : IDLE;
      FETCH: if (gray_req_q) begin
        if (r_q == 2'd0)
          for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
          end
        for (int i = 0; i < 3; i++) if (r_q == 2'(i)) win_d[i][2] = gray_data;
        r_d = r_q == 2'd2 ? 2'd0 : r_q + 2'd1;
        if (r_q == 2'd2) begin
          x_d = x_q + XW'(1);
          if (x_q >= XW'(2)) begin
            state_d     = WRITE;
            lbp_valid_d = 1'b1;
            lbp_addr_d  = addr_of(y_q, x_q - XW'(1));
            lbp_data_d  = code;
          end
        end
      end
      WRITE: if (x_q == XW'(IMG_W)) begin
        if (y_q == YW'(IMG_H - 2)) begin
`ifdef LBP_BORDER_WRITE_EN
          state_d = BORDER;
          x_d     = '0;
          y_d     = '0;
`else
          state_d  = DONE;
          finish_d = 1'b1;
`endif
        end else begin
          state_d = FETCH;
          x_d     = '0;
          y_d     = y_q + YW'(1);
        end
      end else state_d = FETCH;
`ifdef LBP_BORDER_WRITE_EN
      BORDER: if (y_q == YW'(IMG_H)) begin
        state_d  = DONE;
        finish_d = 1'b1;
      end else begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = addr_of(y_q, x_q);
        lbp_data_d  = '0;
        if (y_q == '0 || y_q == YW'(IMG_H - 1)) begin
          x_d = x_q == XW'(IMG_W - 1) ? '0 : x_q + XW'(1);
          y_d = x_q == XW'(IMG_W - 1) ? y_q + YW'(1) : y_q;
        end else begin
          x_d = x_q == '0 ? XW'(IMG_W - 1) : '0;
          y_d = x_q == '0 ? y_q : y_q + YW'(1);
        end
      end
`endif
      default: ;
    endcase
    gray_req_d  = state_d == FETCH && gray_ready;
    gray_addr_d = state_d == FETCH ? addr_of(y_d + YW'(r_d) - YW'(1), x_d) : gray_addr_q;
  end
  // state, window and registered outputs; reset restarts the frame at row 1
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= YW'(1);
      r_q         <= '0;
      win_q       <= '{default: '0};
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      r_q         <= r_d;
      win_q       <= win_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
    end
  end
  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;
endmodule

// File: tb/tb_lbp_engine.sv
// tb_lbp_engine: scoreboard bench for lbp_engine on a small frame
module tb_lbp_engine;
  localparam int W = 12, H = 10, AW = 7, N = W * H;
  logic clk = 1'b0, reset = 1'b1, gray_ready = 1'b0;
  logic gray_req, lbp_valid, finish;
  logic [AW-1:0] gray_addr, lbp_addr;
  logic [7:0] gray_data, lbp_data;
  logic [7:0] img [N];
  logic [7:0] mem [N];
  typedef struct {int a; int d;} exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0, n_wr = 0;
  always #5 clk = ~clk;
  assign gray_data = gray_req ? img[gray_addr] : 8'h5a;
  lbp_engine #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  function automatic bit is_border(input int a);
    return a % W == 0 || a % W == W - 1 || a / W == 0 || a / W == H - 1;
  endfunction
  function automatic int golden(input int x, input int y);
    int dx[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dy[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int c = 0;
    for (int p = 0; p < 8; p++)
      if (img[(y + dy[p]) * W + x + dx[p]] >= img[y * W + x]) c += 1 << p;
    return c;
  endfunction
  task automatic load_expected();
    sb.delete();
    for (int y = 1; y < H - 1; y++)
      for (int x = 1; x < W - 1; x++) sb.push_back('{y * W + x, golden(x, y)});
`ifdef LBP_BORDER_WRITE_EN
    for (int a = 0; a < N; a++) if (is_border(a)) sb.push_back('{a, 0});
`endif
  endtask
  always @(negedge clk) if (lbp_valid) begin
    exp_t e;
    n_wr++;
    mem[lbp_addr] = lbp_data;
    if (sb.size() == 0) check("extra_write", int'(lbp_addr), -1);
    else begin
      e = sb.pop_front();
      check("wr_addr", int'(lbp_addr), e.a);
      check("wr_data", int'(lbp_data), e.d);
    end
  end
  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"}, gray_req, 0);
    check({tag, "_gaddr"}, int'(gray_addr), 0);
    check({tag, "_valid"}, lbp_valid, 0);
    check({tag, "_laddr"}, int'(lbp_addr), 0);
    check({tag, "_ldata"}, int'(lbp_data), 0);
    check({tag, "_finish"}, finish, 0);
  endtask
  task automatic start_frame(input int kind);
    @(posedge clk);
    #1 reset = 1'b1;
    gray_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < N; a++) begin
      img[a] = kind == 0 ? 8'd0 : kind == 1 ? 8'(a % W) : kind == 2 ? (a == 5 * W + 5 ? 8'd0 : 8'd10) :
               kind == 3 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      mem[a] = 8'haa;
    end
    load_expected();
    reset = 1'b0;
    gray_ready = 1'b1;
  endtask
  task automatic wait_finish(input string tag);
    int c = 0;
    while (!finish && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_finish"}, finish, 1);
    check({tag, "_sb_left"}, sb.size(), 0);
    repeat (5) @(negedge clk);
    check({tag, "_req_after"}, gray_req, 0);
    check({tag, "_valid_after"}, lbp_valid, 0);
    check({tag, "_finish_held"}, finish, 1);
  endtask
  task automatic check_mem(input string tag);
    for (int a = 0; a < N; a++)
`ifdef LBP_BORDER_WRITE_EN
      check(tag, int'(mem[a]), is_border(a) ? 0 : golden(a % W, a / W));
`else
      check(tag, int'(mem[a]), is_border(a) ? 'haa : golden(a % W, a / W));
`endif
  endtask
  initial begin
    int c, base;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("rst");
    start_frame(0);
    wait_finish("zero");
    check("zero_code", int'(mem[W + 1]), 'hff);
    check_mem("zero_mem");
    start_frame(1);
    wait_finish("ramp");
    check("ramp_code", int'(mem[2 * W + 3]), 'hd6);
    check_mem("ramp_mem");
    start_frame(2);
    wait_finish("spot");
    check("spot_centre", int'(mem[5 * W + 5]), 'hff);
    check("spot_ul", int'(mem[4 * W + 4]), 'h7f);
    check("spot_lr", int'(mem[6 * W + 6]), 'hfe);
    check_mem("spot_mem");
    start_frame(3);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk);
    #1;
    for (int a = 0; a < N; a++) mem[a] = 8'haa;
    load_expected();
    reset = 1'b0;
    wait_finish("midrst");
    check_mem("midrst_mem");
    start_frame(4);
    c = 0;
    base = n_wr;
    while (n_wr < base + 12 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("stall_wait", int'(c < 1000), 1);
    @(posedge clk);
    #1 gray_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall_valid", lbp_valid, 0);
      if (k > 0) check("stall_req", gray_req, 0);
    end
    @(posedge clk);
    #1 gray_ready = 1'b1;
    wait_finish("stall");
    check_mem("stall_mem");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
